// File: rtl/coin_return_dispenser.sv
// Greedy coin-return dispenser: pays out an amount with three coin values.
// Optional ack watchdog enabled by defining COIN_TIMEOUT_EN.
module coin_return_dispenser #(
   parameter int TOTAL_BITS  = 31,
   parameter int COIN0_VALUE = 100,
   parameter int COIN1_VALUE = 500,
   parameter int COIN2_VALUE = 1000,
   parameter int ACK_TIMEOUT = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i_req_valid,
   input  logic [TOTAL_BITS-1:0] i_req_amount,
   output logic                  o_req_ready,
   output logic [2:0]            o_coin_eject,
   input  logic                  i_hopper_ack,
   output logic                  o_busy,
   output logic                  o_done,
   output logic [TOTAL_BITS-1:0] o_remainder,
   output logic                  o_fault
);

   localparam logic [TOTAL_BITS-1:0] C0 = TOTAL_BITS'(COIN0_VALUE);
   localparam logic [TOTAL_BITS-1:0] C1 = TOTAL_BITS'(COIN1_VALUE);
   localparam logic [TOTAL_BITS-1:0] C2 = TOTAL_BITS'(COIN2_VALUE);

`ifdef COIN_TIMEOUT_EN
   typedef enum logic [2:0] {IDLE, SELECT, EJECT, DONE, FAULT} state_t;
   localparam int CW = $clog2(ACK_TIMEOUT + 1);
   logic [CW-1:0] wait_cnt;
`else
   typedef enum logic [2:0] {IDLE, SELECT, EJECT, DONE} state_t;
`endif

   state_t                state;
   logic [TOTAL_BITS-1:0] remaining;
   logic [TOTAL_BITS-1:0] coin_value;
   logic [2:0]            pick;
   logic [TOTAL_BITS-1:0] pick_value;

   // Largest coin that still fits in what is left
   always_comb begin
      pick       = 3'b000;
      pick_value = '0;
      if (remaining >= C2) begin
         pick       = 3'b100;
         pick_value = C2;
      end else if (remaining >= C1) begin
         pick       = 3'b010;
         pick_value = C1;
      end else if (remaining >= C0) begin
         pick       = 3'b001;
         pick_value = C0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         o_req_ready  <= 1'b1;
         o_coin_eject <= 3'b000;
         o_busy       <= 1'b0;
         o_done       <= 1'b0;
         o_remainder  <= '0;
         remaining    <= '0;
         coin_value   <= '0;
`ifdef COIN_TIMEOUT_EN
         o_fault      <= 1'b0;
         wait_cnt     <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (i_req_valid) begin
                  remaining   <= i_req_amount;
                  state       <= SELECT;
                  o_req_ready <= 1'b0;
                  o_busy      <= 1'b1;
               end
            end
            SELECT: begin
               if (pick != 3'b000) begin
                  o_coin_eject <= pick;
                  coin_value   <= pick_value;
                  state        <= EJECT;
`ifdef COIN_TIMEOUT_EN
                  wait_cnt     <= '0;
`endif
               end else begin
                  o_done      <= 1'b1;
                  o_remainder <= remaining;
                  state       <= DONE;
               end
            end
            EJECT: begin
               if (i_hopper_ack) begin
                  remaining    <= remaining - coin_value;
                  o_coin_eject <= 3'b000;
                  state        <= SELECT;
`ifdef COIN_TIMEOUT_EN
               end else if (wait_cnt == CW'(ACK_TIMEOUT - 1)) begin
                  o_coin_eject <= 3'b000;
                  o_fault      <= 1'b1;
                  o_remainder  <= remaining;
                  state        <= FAULT;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
`endif
               end
            end
            DONE: begin
               o_done      <= 1'b0;
               o_busy      <= 1'b0;
               o_req_ready <= 1'b1;
               state       <= IDLE;
            end
`ifdef COIN_TIMEOUT_EN
            FAULT: begin
               o_fault     <= 1'b0;
               o_busy      <= 1'b0;
               o_req_ready <= 1'b1;
               state       <= IDLE;
            end
`endif
            default: state <= IDLE;
         endcase
      end
   end

`ifndef COIN_TIMEOUT_EN
   assign o_fault = 1'b0;
`endif

endmodule

// File: tb/tb_coin_return_dispenser.sv
// Bench for coin_return_dispenser: directed cases plus random amounts
// checked against an arithmetic greedy-change model.
module tb_coin_return_dispenser;

   logic        clk = 1'b0;
   logic        reset;
   logic        i_req_valid;
   logic [30:0] i_req_amount;
   logic        o_req_ready;
   logic [2:0]  o_coin_eject;
   logic        i_hopper_ack;
   logic        o_busy;
   logic        o_done;
   logic [30:0] o_remainder;
   logic        o_fault;

   int n_cmp = 0;
   int n_err = 0;

   coin_return_dispenser dut (
      .clk          (clk),
      .reset        (reset),
      .i_req_valid  (i_req_valid),
      .i_req_amount (i_req_amount),
      .o_req_ready  (o_req_ready),
      .o_coin_eject (o_coin_eject),
      .i_hopper_ack (i_hopper_ack),
      .o_busy       (o_busy),
      .o_done       (o_done),
      .o_remainder  (o_remainder),
      .o_fault      (o_fault)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // delay < 0 picks a random ack delay of 0..3 cycles per coin
   task automatic run_req(input int amt, input int delay);
      int q[$];
      int a;
      int rem;
      int t;
      int d;
      a = amt;
      repeat (a / 1000) q.push_back(4);
      a = a % 1000;
      repeat (a / 500) q.push_back(2);
      a = a % 500;
      repeat (a / 100) q.push_back(1);
      rem = a % 100;
      t = 0;
      while (!o_req_ready && t < 50) begin
         step();
         t++;
      end
      check("ready_before", 32'(o_req_ready), 1);
      i_req_valid  = 1'b1;
      i_req_amount = 31'(amt);
      step();
      i_req_valid  = 1'b0;
      i_req_amount = 31'($urandom);
      i_hopper_ack = 1'($urandom_range(0, 1));
      check("busy_select", 32'({o_busy, o_req_ready}), 2);
      check("no_eject_select", 32'(o_coin_eject), 0);
      step();
      i_hopper_ack = 1'b0;
      foreach (q[k]) begin
         d = (delay < 0) ? int'($urandom_range(0, 3)) : delay;
         check("eject", 32'(o_coin_eject), q[k]);
         for (int c = 0; c < d; c++) begin
            i_req_valid = 1'($urandom_range(0, 1));
            step();
            check("eject_hold", 32'(o_coin_eject), q[k]);
         end
         i_hopper_ack = 1'b1;
         i_req_valid  = 1'($urandom_range(0, 1));
         step();
         i_hopper_ack = 1'b0;
         i_req_valid  = 1'b0;
         check("eject_drop", 32'(o_coin_eject), 0);
         check("no_done_mid", 32'(o_done), 0);
         step();
      end
      check("done", 32'(o_done), 1);
      check("remainder", 32'(o_remainder), rem);
      check("no_eject_done", 32'(o_coin_eject), 0);
      check("fault_low", 32'(o_fault), 0);
      step();
      check("done_pulse", 32'(o_done), 0);
      check("idle_ready", 32'({o_busy, o_req_ready}), 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset        = 1'b1;
      i_req_valid  = 1'b0;
      i_req_amount = '0;
      i_hopper_ack = 1'b0;
      repeat (3) step();
      check("rst_ready", 32'(o_req_ready), 1);
      check("rst_eject", 32'(o_coin_eject), 0);
      check("rst_busy", 32'(o_busy), 0);
      check("rst_done", 32'(o_done), 0);
      check("rst_rem", 32'(o_remainder), 0);
      check("rst_fault", 32'(o_fault), 0);
      reset = 1'b0;
      step();

      run_req(1600, 0);
      run_req(250, 0);
      run_req(50, 0);
      run_req(0, 0);
      run_req(1000, 5);

      // reset during first eject abandons the return
      i_req_valid  = 1'b1;
      i_req_amount = 31'd1500;
      step();
      i_req_valid = 1'b0;
      step();
      check("rst_mid_eject_on", 32'(o_coin_eject), 4);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("rst_mid_drop", 32'(o_coin_eject), 0);
      check("rst_mid_idle", 32'({o_busy, o_req_ready}), 1);
      for (int c = 0; c < 6; c++) begin
         step();
         check("rst_mid_no_done", 32'({o_done, o_coin_eject}), 0);
      end

`ifdef COIN_TIMEOUT_EN
      i_req_valid  = 1'b1;
      i_req_amount = 31'd500;
      step();
      i_req_valid = 1'b0;
      step();
      for (int c = 0; c < 16; c++) begin
         check("to_eject", 32'({o_fault, o_coin_eject}), 2);
         step();
      end
      check("to_fault", 32'({o_fault, o_coin_eject}), 8);
      check("to_rem", 32'(o_remainder), 500);
      check("to_no_done", 32'(o_done), 0);
      step();
      check("to_fault_pulse", 32'(o_fault), 0);
      check("to_idle", 32'({o_busy, o_req_ready}), 1);
`else
      i_req_valid  = 1'b1;
      i_req_amount = 31'd500;
      step();
      i_req_valid = 1'b0;
      step();
      for (int c = 0; c < 40; c++) begin
         if (c % 8 == 0)
            check("hold_eject", 32'({o_fault, o_coin_eject}), 2);
         step();
      end
      check("hold_eject_end", 32'({o_fault, o_coin_eject}), 2);
      i_hopper_ack = 1'b1;
      step();
      i_hopper_ack = 1'b0;
      step();
      check("hold_done", 32'(o_done), 1);
      check("hold_rem", 32'(o_remainder), 0);
      step();
`endif

      for (int r = 0; r < 25; r++)
         run_req(int'($urandom_range(0, 4000)), -1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
